datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Control FSM for the datapath. Pulses `increment` to advance the datapath
//  program counter, latches the returned 8-bit `instruction`, and decodes it.
//  Executes each instruction as a short sequence of one-hot bus-source (`rout`)
//  and bus-destination (`ren`) strobes, plus the ALU add/xor select (`addxor`).
//  Sits directly above the datapath and is its only driver.
// PARAMETERS
//  NREG      8   general registers r0..r(NREG-1); map to rout/ren bits [NREG-1:0]
//  A_BIT     8   rout/ren bit index of ALU operand register A
//  G_BIT     9   rout/ren bit index of ALU result register G
// PORTS
//  clock        in   1   rising-edge clock
//  reset        in   1   synchronous, active-high reset
//  run          in   1   level; while 1, fetch/execute continuously; 0 = stop at next FETCH
//  instruction  in   8   instruction from datapath, valid 1 cycle after increment pulse
//  rout         out  16  one-hot bus source select (all-zero = bus idle)
//  ren          out  16  one-hot bus destination load enable
//  addxor       out  1   ALU op: 0 = add, 1 = xor (meaningful only when ren[G_BIT]=1)
//  increment    out  1   1-cycle pulse; datapath PC advances on its rising edge
//  busy         out  1   1 in any state except IDLE/HALT
//  halted       out  1   1 in HALT
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0; FSM goes to IDLE.
//  - Instruction format: op=[7:6], rx=[5:3], ry=[2:0].
//    00 MV rx<-ry | 01 ADD rx<-rx+ry | 10 XOR rx<-rx^ry | 11 CTL (ry=111 HALT, else NOP).
//  - States: IDLE, FETCH, LATCH, EXEC1, EXEC2, EXEC3, HALT.
//  - IDLE:  run=1 -> FETCH.
//  - FETCH: increment=1 for this cycle only -> LATCH.
//  - LATCH: capture instruction into internal ir -> EXEC1.
//  - MV:  EXEC1 rout[ry]=1, ren[rx]=1 -> done.
//  - ADD/XOR:
//      EXEC1 rout[rx], ren[A_BIT]
//      EXEC2 rout[ry], ren[G_BIT], addxor=op[1]
//      EXEC3 rout[G_BIT], ren[rx] -> done
//  - NOP: EXEC1 with rout=ren=0 -> done.  HALT: EXEC1 idle -> HALT.
//  - done: run=1 -> FETCH, run=0 -> IDLE.
//  - Latency from FETCH: MV/NOP 3 cycles, ADD/XOR 5 cycles. increment never
//    pulses back-to-back; minimum 2 idle cycles between pulses.
//  - rout and ren are each zero or exactly one-hot every cycle; bits [15:10] are
//    always 0. rx==ry is legal (MV rx,rx drives the same bit in both).
//  - HALT is sticky: leave only via reset; run is ignored.
//  - run deasserted mid-instruction: the current instruction completes, then IDLE.
//  - reset mid-instruction: the next edge zeroes all outputs and enters IDLE.
//    A partially executed ALU op is abandoned (A/G may be stale; rx is unwritten).
//    The datapath PC is not rewound.
// CONFIGURATION
//  DATAPATH_SEQ_SINGLE_STEP_EN
//    Defined: adds input port `step` (1 bit). At done, the FSM enters IDLE
//      regardless of run. It leaves IDLE to FETCH only on a cycle where
//      step=1 && run=1, giving exactly one instruction per step pulse.
//    Undefined: no `step` port; continuous execution as described above.
// TESTING
//  1. Reset held 3 cycles -> every output 0; busy=0, halted=0, state IDLE.
//  2. run=1, instr 8'b00_010_001 (MV r2<-r1) -> one increment pulse; EXEC1 shows
//     rout=16'h0002, ren=16'h0004; busy falls if run=0.
//  3. Instr 8'b01_011_101 (ADD r3,r5) -> rout/ren sequence 0008/0100, 0020/0200
//     (addxor=0), 0200/0008; 5 cycles FETCH-to-done.
//  4. Instr 8'b10_000_001 (XOR r0,r1) -> addxor=1 in EXEC2 only; 8'b11_000_111
//     -> halted=1, busy=0, no further increment pulses even with run=1.
//  5. Assert reset during EXEC2 of ADD -> next cycle all outputs 0, IDLE; with
//     run=1 the next FETCH occurs 1 cycle after reset drops.
//  6. SINGLE_STEP_EN: run=1, step pulsed 3 times -> exactly 3 increment pulses,
//     FSM in IDLE between steps.

Source files
------------

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: fetch/latch/execute control FSM driving one-hot bus strobes for the datapath.
// Optional DATAPATH_SEQ_SINGLE_STEP_EN adds a step input that runs one instruction per step pulse.
module datapath_sequencer #(
    parameter int NREG  = 8,
    parameter int A_BIT = 8,
    parameter int G_BIT = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
`ifdef DATAPATH_SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [7:0]  instruction,
    output logic [15:0] rout,
    output logic [15:0] ren,
    output logic        addxor,
    output logic        increment,
    output logic        busy,
    output logic        halted
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, EXEC1, EXEC2, EXEC3, HALT} state_t;
    state_t state;
    logic [7:0] ir;
    logic [$clog2(NREG)-1:0] in_rx, in_ry, ir_rx, ir_ry;
    logic start, cont, alu_ir, halt_ir, fin;
`ifdef DATAPATH_SEQ_SINGLE_STEP_EN
    assign start = run & step;
    assign cont  = 1'b0;
`else
    assign start = run;
    assign cont  = run;
`endif
    assign in_rx   = instruction[5:3];
    assign in_ry   = instruction[2:0];
    assign ir_rx   = ir[5:3];
    assign ir_ry   = ir[2:0];
    assign alu_ir  = ir[7] ^ ir[6];
    assign halt_ir = &{ir[7:6], ir[2:0]};
    assign fin     = state == EXEC3 || (state == EXEC1 && !alu_ir && !halt_ir);

    function automatic logic [15:0] one_hot(input logic [3:0] i);
        return 16'b1 << i;
    endfunction

    // Outputs are computed for the state being entered, so they are valid during that state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ir        <= '0;
            rout      <= '0;
            ren       <= '0;
            addxor    <= 1'b0;
            increment <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            rout      <= '0;
            ren       <= '0;
            addxor    <= 1'b0;
            increment <= 1'b0;
            if (fin) begin
                state     <= cont ? FETCH : IDLE;
                increment <= cont;
                busy      <= cont;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state     <= FETCH;
                        increment <= 1'b1;
                        busy      <= 1'b1;
                    end
                    FETCH: state <= LATCH;
                    LATCH: begin
                        ir    <= instruction;
                        state <= EXEC1;
                        if (instruction[7:6] == 2'b00) begin
                            rout <= one_hot(4'(in_ry));
                            ren  <= one_hot(4'(in_rx));
                        end else if (instruction[7] ^ instruction[6]) begin
                            rout <= one_hot(4'(in_rx));
                            ren  <= one_hot(4'(A_BIT));
                        end
                    end
                    EXEC1: if (alu_ir) begin
                        state  <= EXEC2;
                        rout   <= one_hot(4'(ir_ry));
                        ren    <= one_hot(4'(G_BIT));
                        addxor <= ir[7];
                    end else begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end
                    EXEC2: begin
                        state <= EXEC3;
                        rout  <= one_hot(4'(G_BIT));
                        ren   <= one_hot(4'(ir_rx));
                    end
                    HALT: state <= HALT;
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed cycle-by-cycle checks of the sequencer outputs.
module tb_datapath_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  instruction = 8'h00;
    logic [15:0] rout, ren;
    logic        addxor, increment, busy, halted;
    int          vectors = 0;
    int          miscompares = 0;
`ifdef DATAPATH_SEQ_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    datapath_sequencer dut (
        .clock(clk),
        .reset(reset),
        .run(run),
`ifdef DATAPATH_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .instruction(instruction),
        .rout(rout),
        .ren(ren),
        .addxor(addxor),
        .increment(increment),
        .busy(busy),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic expect_cyc(input string tag, input logic [15:0] ro, input logic [15:0] re,
                              input logic ax, input logic inc, input logic bz, input logic hl);
        @(negedge clk);
        vectors++;
        assert ({rout, ren, addxor, increment, busy, halted} === {ro, re, ax, inc, bz, hl})
        else begin
            miscompares++;
            $error("FAIL %s: observed rout=%h ren=%h addxor=%b inc=%b busy=%b halted=%b, expected rout=%h ren=%h addxor=%b inc=%b busy=%b halted=%b",
                   tag, rout, ren, addxor, increment, busy, halted, ro, re, ax, inc, bz, hl);
        end
    endtask

    initial begin
        expect_cyc("reset0", 0, 0, 0, 0, 0, 0);
        expect_cyc("reset1", 0, 0, 0, 0, 0, 0);
        expect_cyc("reset2", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        expect_cyc("idle_run0", 0, 0, 0, 0, 0, 0);

        // MV r2<-r1, run dropped after fetch
        instruction = 8'b00_010_001;
        run = 1'b1;
        expect_cyc("mv_fetch", 0, 0, 0, 1, 1, 0);
        run = 1'b0;
        expect_cyc("mv_latch", 0, 0, 0, 0, 1, 0);
        expect_cyc("mv_exec1", 16'h0002, 16'h0004, 0, 0, 1, 0);
        expect_cyc("mv_idle", 0, 0, 0, 0, 0, 0);

        // ADD r3,r5
        instruction = 8'b01_011_101;
        run = 1'b1;
        expect_cyc("add_fetch", 0, 0, 0, 1, 1, 0);
        run = 1'b0;
        expect_cyc("add_latch", 0, 0, 0, 0, 1, 0);
        expect_cyc("add_exec1", 16'h0008, 16'h0100, 0, 0, 1, 0);
        expect_cyc("add_exec2", 16'h0020, 16'h0200, 0, 0, 1, 0);
        expect_cyc("add_exec3", 16'h0200, 16'h0008, 0, 0, 1, 0);
        expect_cyc("add_idle", 0, 0, 0, 0, 0, 0);

`ifndef DATAPATH_SEQ_SINGLE_STEP_EN
        // continuous run: MV r1<-r1 twice, two idle cycles between increments
        instruction = 8'b00_001_001;
        run = 1'b1;
        expect_cyc("cont_fetch0", 0, 0, 0, 1, 1, 0);
        expect_cyc("cont_latch0", 0, 0, 0, 0, 1, 0);
        expect_cyc("cont_exec0", 16'h0002, 16'h0002, 0, 0, 1, 0);
        expect_cyc("cont_fetch1", 0, 0, 0, 1, 1, 0);
        expect_cyc("cont_latch1", 0, 0, 0, 0, 1, 0);
        expect_cyc("cont_exec1", 16'h0002, 16'h0002, 0, 0, 1, 0);
        run = 1'b0;
        expect_cyc("cont_idle", 0, 0, 0, 0, 0, 0);
`endif

        // XOR r0,r1
        instruction = 8'b10_000_001;
        run = 1'b1;
        expect_cyc("xor_fetch", 0, 0, 0, 1, 1, 0);
        run = 1'b0;
        expect_cyc("xor_latch", 0, 0, 0, 0, 1, 0);
        expect_cyc("xor_exec1", 16'h0001, 16'h0100, 0, 0, 1, 0);
        expect_cyc("xor_exec2", 16'h0002, 16'h0200, 1, 0, 1, 0);
        expect_cyc("xor_exec3", 16'h0200, 16'h0001, 0, 0, 1, 0);
        expect_cyc("xor_idle", 0, 0, 0, 0, 0, 0);

        // NOP
        instruction = 8'b11_000_011;
        run = 1'b1;
        expect_cyc("nop_fetch", 0, 0, 0, 1, 1, 0);
        run = 1'b0;
        expect_cyc("nop_latch", 0, 0, 0, 0, 1, 0);
        expect_cyc("nop_exec1", 0, 0, 0, 0, 1, 0);
        expect_cyc("nop_idle", 0, 0, 0, 0, 0, 0);

        // reset during EXEC2 of ADD, then restart with run held
        instruction = 8'b01_011_101;
        run = 1'b1;
        expect_cyc("rst_fetch", 0, 0, 0, 1, 1, 0);
        expect_cyc("rst_latch", 0, 0, 0, 0, 1, 0);
        expect_cyc("rst_exec1", 16'h0008, 16'h0100, 0, 0, 1, 0);
        expect_cyc("rst_exec2", 16'h0020, 16'h0200, 0, 0, 1, 0);
        reset = 1'b1;
        expect_cyc("rst_mid", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        expect_cyc("rst_refetch", 0, 0, 0, 1, 1, 0);
        run = 1'b0;
        expect_cyc("rst_relatch", 0, 0, 0, 0, 1, 0);
        expect_cyc("rst_reexec1", 16'h0008, 16'h0100, 0, 0, 1, 0);
        expect_cyc("rst_reexec2", 16'h0020, 16'h0200, 0, 0, 1, 0);
        expect_cyc("rst_reexec3", 16'h0200, 16'h0008, 0, 0, 1, 0);
        expect_cyc("rst_idle", 0, 0, 0, 0, 0, 0);

        // HALT is sticky with run held
        instruction = 8'b11_000_111;
        run = 1'b1;
        expect_cyc("halt_fetch", 0, 0, 0, 1, 1, 0);
        expect_cyc("halt_latch", 0, 0, 0, 0, 1, 0);
        expect_cyc("halt_exec1", 0, 0, 0, 0, 1, 0);
        expect_cyc("halt_enter", 0, 0, 0, 0, 0, 1);
        expect_cyc("halt_stay0", 0, 0, 0, 0, 0, 1);
        expect_cyc("halt_stay1", 0, 0, 0, 0, 0, 1);
        expect_cyc("halt_stay2", 0, 0, 0, 0, 0, 1);

`ifdef DATAPATH_SEQ_SINGLE_STEP_EN
        // single step: three step pulses give three instructions, IDLE in between
        reset = 1'b1;
        step = 1'b0;
        expect_cyc("ss_reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        instruction = 8'b00_010_001;
        expect_cyc("ss_wait0", 0, 0, 0, 0, 0, 0);
        expect_cyc("ss_wait1", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            expect_cyc("ss_fetch", 0, 0, 0, 1, 1, 0);
            step = 1'b0;
            expect_cyc("ss_latch", 0, 0, 0, 0, 1, 0);
            expect_cyc("ss_exec1", 16'h0002, 16'h0004, 0, 0, 1, 0);
            expect_cyc("ss_idle0", 0, 0, 0, 0, 0, 0);
            expect_cyc("ss_idle1", 0, 0, 0, 0, 0, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
